// File: rtl/alu_pkg.sv
// Common decoded ALU function encoding shared by the execute stage units.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MULT,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alufunc_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero, overflow and unsupported ops.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  alufunc_t        in_func,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    // Handshake: a request transfers on a cycle with in_valid && in_ready; a result
    // transfers on a cycle with out_valid && out_ready. flush overrides both.

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc, opa, opb, result;
    logic            word_q, mul_q, rem_q, negq_q, negr_q;

    logic            accept, is_mul, is_signed, is_rem, is_divop, supported;
    logic            div_zero, ovf, fast;
    logic [XLEN-1:0] a_p, b_p, a_mag, b_mag, fast_res;
    logic [XLEN:0]   rs, diff;
    logic            ge;
    logic [XLEN-1:0] acc_nx, opa_nx, opb_nx, raw, final_res;

    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    always_comb begin
        is_mul    = (in_func == ALU_MULT);
        is_signed = (in_func == ALU_DIV) || (in_func == ALU_REM);
        is_rem    = (in_func == ALU_REM) || (in_func == ALU_REMU);
        is_divop  = is_signed || (in_func == ALU_DIVU) || (in_func == ALU_REMU);
        supported = is_mul || is_divop;
        a_p = in_a;
        b_p = in_b;
        if (in_word) begin
            a_p = is_signed ? wfix(1'b1, in_a) : {{(XLEN-WLEN){1'b0}}, in_a[WLEN-1:0]};
            b_p = is_signed ? wfix(1'b1, in_b) : {{(XLEN-WLEN){1'b0}}, in_b[WLEN-1:0]};
        end
        a_mag    = (is_signed && a_p[XLEN-1]) ? -a_p : a_p;
        b_mag    = (is_signed && b_p[XLEN-1]) ? -b_p : b_p;
        div_zero = is_divop && (b_p == '0);
        ovf      = is_signed && (a_p == (in_word ? MIN_W : MIN_X)) && (b_p == '1);
        fast     = !supported || div_zero || ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = wfix(in_word, is_rem ? a_p : '1);
        else if (ovf)
            fast_res = is_rem ? '0 : wfix(in_word, a_p);
    end

    // One iteration step; for divide, opa holds the dividend shifting out and the quotient shifting in.
    always_comb begin
        rs   = {acc, opa[XLEN-1]};
        diff = rs - {1'b0, opb};
        ge   = !diff[XLEN];
        if (mul_q) begin
            acc_nx = acc + (opb[0] ? opa : '0);
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
            raw    = acc_nx;
        end else begin
            acc_nx = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
            opa_nx = {opa[XLEN-2:0], ge};
            opb_nx = opb;
            if (rem_q)
                raw = negr_q ? -acc_nx : acc_nx;
            else
                raw = negq_q ? -opa_nx : opa_nx;
        end
        final_res = wfix(word_q, raw);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) && !flush;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nx = fast ? DONE : BUSY;
                BUSY: if (count == CW'(1)) state_nx = DONE;
                DONE: if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            word_q <= 1'b0;
            mul_q  <= 1'b0;
            rem_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            count  <= fast ? '0 : (in_word ? CW'(WLEN) : CW'(XLEN));
            acc    <= '0;
            opa    <= is_mul ? a_p : (in_word ? (a_mag << WLEN) : a_mag);
            opb    <= is_mul ? b_p : b_mag;
            result <= fast_res;
            word_q <= in_word;
            mul_q  <= is_mul;
            rem_q  <= is_rem;
            negq_q <= is_signed && (a_p[XLEN-1] ^ b_p[XLEN-1]);
            negr_q <= is_signed && a_p[XLEN-1];
        end else if (state == BUSY) begin
            count <= count - CW'(1);
            acc   <= acc_nx;
            opa   <= opa_nx;
            opb   <= opb_nx;
            if (count == CW'(1))
                result <= final_res;
        end
    end

    assign out_result = result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage.
- Consumes the decoded ALU function for the RV64M subset: MULT, DIV, DIVU, REM, REMU, in both 64-bit (ALU op) and word (ALUW op) forms.
- The execute stage stalls the pipeline while the unit is busy. Results return through a valid/ready handshake.

Parameters:
- XLEN, 64, operand/result width.
- WLEN, 32, word-form operand width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- in_func  input  alufunc_t  MULT/DIV/DIVU/REM/REMU (common package enum).
- in_word  input  1  word form: operands use low 32 bits, result sign-extended from bit 31.
- in_a  input  XLEN  rs1 value.
- in_b  input  XLEN  rs2 value.
- flush  input  1  abort current operation (branch/exception redirect).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_result  output  XLEN  result.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and reset only, no asynchronous logic.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0.
- FSM states are IDLE, BUSY and DONE.
- in_ready = (state==IDLE) && !flush.
- Accept occurs when in_valid && in_ready (cycle T).
- Operands are latched at accept; later changes on in_* are ignored.
- Word form operand preparation:
  - signed ops (DIV, REM): sign-extend in_a[31:0] and in_b[31:0];
  - unsigned ops (DIVU, REMU): zero-extend them;
  - MULT: use the low 32 bits;
  - iteration count N=WLEN.
- Non-word form: N=XLEN.
- MULT:
  - radix-2 shift-add, one partial-product bit per BUSY cycle;
  - result is the low XLEN (or low WLEN, then sign-extended) bits of the product;
  - signedness is irrelevant to the low bits.
- DIV/DIVU/REM/REMU:
  - restoring division, one quotient bit per BUSY cycle, on magnitudes;
  - signed ops take absolute values at accept and fix signs at completion;
  - quotient is negated iff operand signs differ;
  - remainder takes the dividend's sign.
- Timing: IDLE->BUSY at T with the counter loaded to N. Counter decrements each BUSY cycle. BUSY->DONE when counter==1, so out_valid first rises at cycle T+N+1 (T+65 for 64-bit, T+33 for word).
- Fast-path special cases bypass BUSY (IDLE->DONE, out_valid at T+1):
  - divide by zero (divisor==0 after operand prep): quotient = all ones (then word sign-extension); remainder = dividend;
  - signed overflow (dividend = most negative value of the width, divisor = -1): quotient = dividend; remainder = 0;
  - in_func not one of the five supported: result = 0.
- DONE:
  - out_valid=1 and out_result stay stable until out_ready;
  - on out_valid && out_ready, go DONE->IDLE, so in_ready=1 in the next cycle;
  - no new request is accepted in the same cycle as result handoff.
- Word results: out_result = sign-extension of bit 31 of the 32-bit result, for all word ops including DIVU/REMU.
- Flush:
  - in any state, next state = IDLE and out_valid=0 next cycle;
  - a request presented in the flush cycle is not accepted;
  - flush has priority over out_ready.
- Reset mid-operation has the same effect as flush; all internal registers clear.
- out_ready while not in DONE is ignored.
- in_valid while BUSY/DONE is ignored; in_ready=0 in those states.

Test Plan:
- MULT 64-bit, a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3), out_ready=1 -> out_valid at T+65, result 0xFFFF_FFFF_FFFF_FFEB; in_ready high at T+66.
- Word DIV a=0xFFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD at T+33; word REM same operands -> 0xFFFF_FFFF_FFFF_FFFF; DIVU 64-bit 100/7 -> 14, REMU -> 2.
- Divide by zero: DIV a=42, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REM a=42, b=0 -> 42. Overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000 at T+1; REM -> 0.
- Backpressure: complete MULT 3*5 with out_ready=0 for 10 cycles -> out_valid held, result 15 stable, in_ready=0; out_ready=1 -> handoff, in_ready=1 next cycle.
- Flush at T+20 of a 64-bit DIV -> out_valid never rises, in_ready=1 at T+21. A new MULT 2*3 accepted then -> 6 at 65 cycles after that accept, with no residue from the aborted op.
- Reset asserted at T+10 of a BUSY op -> all outputs at reset values next cycle. A request issued with in_valid held through reset is not accepted until the first cycle after reset deasserts.
